// File: rtl/ones_pkg.sv
// ---------------------------------------------------------------------------
// ones_pkg
//   Shared definitions for the ones-count pipeline.
//   - state_t       : window accumulator FSM states
//   - DEF_WORD_W    : default data word width
//   - DEF_CNT_W     : default ones-count width, $clog2(DEF_WORD_W+1)
//   - clamp_count() : saturate an incoming count to the largest legal value
// ---------------------------------------------------------------------------
package ones_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,   // collecting counts into the current window
      HOLD  = 1'b1    // window result presented, waiting for downstream
   } state_t;

   localparam int unsigned DEF_WORD_W = 8;
   localparam int unsigned DEF_CNT_W  = 4;

   // A count larger than the word width cannot come from a healthy upstream
   // stage; it is replaced by the largest legal value.
   function automatic int unsigned clamp_count(input int unsigned cnt,
                                               input int unsigned max_cnt);
      return (cnt > max_cnt) ? max_cnt : cnt;
   endfunction

endpackage

// File: rtl/ones_window_accumulator.sv
// ---------------------------------------------------------------------------
// ones_window_accumulator
//   Sums WINDOW per-word ones counts into a window total and presents the
//   result over a valid/ready output. A flush pulse closes a partial window
//   early. Counts above WORD_W are clamped and latch a sticky error.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   valid never depends combinationally on ready; once out_valid is high the
//   result fields stay stable until out_ready is seen.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   reset       in   asynchronous active-high reset
//   in_valid    in   bit_count is valid
//   in_ready    out  count accepted this cycle (high in ACCUM)
//   bit_count   in   ones count of one data word (legal 0..WORD_W)
//   flush       in   close a non-empty partial window early
//   out_valid   out  window result valid (high in HOLD)
//   out_ready   in   downstream takes the result
//   window_sum  out  sum of accepted (clamped) counts
//   word_cnt    out  words in the closed window (1..WINDOW)
//   dense_flag  out  window_sum >= THRESH
//   partial     out  window closed by flush before WINDOW words
//   err_sticky  out  an illegal count was seen since reset
// ---------------------------------------------------------------------------
module ones_window_accumulator
   import ones_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W,
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned WINDOW = 16,
   parameter int unsigned SUM_W  = 8,
   parameter int unsigned THRESH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CNT_W-1:0] bit_count,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] window_sum,
   output logic [7:0]       word_cnt,
   output logic             dense_flag,
   output logic             partial,
   output logic             err_sticky
);

   // One extra bit so the word count of a full 256-word window is
   // representable before it is narrowed onto word_cnt.
   localparam int unsigned IDX_W = 9;

   state_t             state, state_next;
   logic [SUM_W-1:0]   acc, acc_next;
   logic [IDX_W-1:0]   idx, idx_next;

   logic               accept;
   logic               illegal;
   logic               last_word;
   logic               flush_close;
   logic               close;
   logic [SUM_W-1:0]   add_val;
   logic [SUM_W-1:0]   sum_close;
   logic [IDX_W-1:0]   cnt_close;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);

   // Next-state, accumulator and index logic.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      idx_next   = idx;

      accept    = (state == ACCUM) && in_valid;
      illegal   = accept && (32'(bit_count) > WORD_W);
      add_val   = SUM_W'(clamp_count(32'(bit_count), WORD_W));

      // Values the window would hold after this cycle's word; an accepted
      // word is always included before a same-cycle flush is considered.
      sum_close = accept ? (acc + add_val) : acc;
      cnt_close = accept ? (idx + IDX_W'(1)) : idx;

      last_word   = accept && (idx == IDX_W'(WINDOW - 1));
      // A flush only matters if the window would be non-empty.
      flush_close = (state == ACCUM) && flush && (cnt_close != '0);
      close       = last_word || flush_close;

      case (state)
         ACCUM: begin
            if (close) begin
               state_next = HOLD;
               acc_next   = '0;
               idx_next   = '0;
            end else if (accept) begin
               acc_next = sum_close;
               idx_next = cnt_close;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = ACCUM;
            end
         end
         default: begin
            state_next = ACCUM;
            acc_next   = '0;
            idx_next   = '0;
         end
      endcase
   end

   // FSM, accumulator, index counter and sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ACCUM;
         acc        <= '0;
         idx        <= '0;
         err_sticky <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         idx   <= idx_next;
         if (illegal) begin
            err_sticky <= 1'b1;
         end
      end
   end

   // Result registers: loaded only on the closing edge and otherwise held,
   // so they stay stable through HOLD and keep their value afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         window_sum <= '0;
         word_cnt   <= '0;
         dense_flag <= 1'b0;
         partial    <= 1'b0;
      end else if (close) begin
         window_sum <= sum_close;
         word_cnt   <= cnt_close[7:0];
         dense_flag <= (32'(sum_close) >= THRESH);
         // A word that fills the window wins over a same-cycle flush.
         partial    <= !last_word;
      end
   end

endmodule
